// File: rtl/mod_mult.sv
// mod_mult: iterative interleaved modular multiplier, Out = (A * B) mod P.
//
// Scans the multiplier B MSB first, one bit per clock. Each iteration
// doubles the accumulator and conditionally adds the multiplicand. A modular
// correction follows each of those two steps, so the accumulator stays fully
// reduced (0 <= R < P) at all times. The result therefore needs no further
// reduction downstream.
//
// Parameters
//   size  operand/result width in bits
//   P     modulus, 2^(size-1) < P < 2^size
//
// Ports
//   Clk    system clock, rising edge
//   Reset  asynchronous, active-high
//   Start  request, sampled only in Idle
//   A      multiplicand, captured at start (any size-bit value; reduced once)
//   B      multiplier, captured at start
//   Out    result register, holds last result until the next Finish
//   Done   high while in Finish
//   Busy   high while in Run

// One interleaved iteration: t = (2r [+ a]) mod P, given r < P and a < P.
// All sums fit in size+1 bits because 2r < 2P and (2r mod P) + a < 2P.
module mod_mult_step #(
  parameter int              size = 256,
  parameter logic [size-1:0] P    = '1
) (
  input  logic [size:0]   r,
  input  logic [size-1:0] a,
  input  logic            b_bit,
  output logic [size:0]   t
);
  localparam logic [size:0] PX = {1'b0, P};

  logic [size:0] dbl, dbl_red, sum, sum_red;

  always_comb begin
    dbl     = r << 1;
    dbl_red = (dbl >= PX) ? dbl - PX : dbl;
    sum     = dbl_red + {1'b0, a};
    sum_red = (sum >= PX) ? sum - PX : sum;
    t       = b_bit ? sum_red : dbl_red;
  end
endmodule

module mod_mult #(
  parameter int              size = 12'h100,
  parameter logic [size-1:0] P    = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [size-1:0] A,
  input  logic [size-1:0] B,
  output logic [size-1:0] Out,
  output logic            Done,
  output logic            Busy
);
  localparam int CW = $clog2(size) + 1;  // bit counter width
  localparam int IW = $clog2(size);      // enough to index b_reg

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [size-1:0] a_reg, b_reg;
  logic [size:0]   r;
  logic [CW-1:0]   cnt;

  logic [size-1:0] a_red;
  logic            b_bit;
  logic [size:0]   t;

  // A may be anywhere below 2^size < 2P, so a single subtraction reduces it.
  assign a_red = (A >= P) ? A - P : A;
  assign b_bit = b_reg[cnt[IW-1:0]];

  mod_mult_step #(.size(size), .P(P)) u_step (
    .r     (r),
    .a     (a_reg),
    .b_bit (b_bit),
    .t     (t)
  );

  // State register and datapath registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      r     <= '0;
      cnt   <= '0;
      Out   <= '0;
    end else begin
      state <= state_d;
      case (state)
        IDLE: begin
          if (Start) begin
            a_reg <= a_red;
            b_reg <= B;
            r     <= '0;
            cnt   <= CW'(size - 1);
          end
        end
        RUN: begin
          r <= t;
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           Out <= t[size-1:0];
        end
        default: ;
      endcase
    end
  end

  // Next state and Moore outputs.
  always_comb begin
    state_d = state;
    Done    = 1'b0;
    Busy    = 1'b0;
    case (state)
      IDLE: begin
        if (Start) state_d = RUN;
      end
      RUN: begin
        Busy = 1'b1;
        if (cnt == '0) state_d = FINISH;
      end
      FINISH: begin
        Done = 1'b1;
        // Start must drop before another operation can be accepted.
        if (!Start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mod_mult.sv
module tb_mod_mult;
  localparam logic [7:0]   P8   = 8'hFB;
  localparam logic [255:0] P256 = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic         rst8, st8, done8, busy8;
  logic [7:0]   a8, b8, out8;
  logic         rst256, st256, done256, busy256;
  logic [255:0] a256, b256, out256;

  mod_mult #(.size(8), .P(8'hFB)) u8 (
    .Clk(Clk), .Reset(rst8), .Start(st8), .A(a8), .B(b8),
    .Out(out8), .Done(done8), .Busy(busy8)
  );

  mod_mult u256 (
    .Clk(Clk), .Reset(rst256), .Start(st256), .A(a256), .B(b256),
    .Out(out256), .Done(done256), .Busy(busy256)
  );

  int n_chk = 0, n_pass = 0;
  int r_viol = 0;
  logic [7:0]   q8[$];
  logic [255:0] q256[$];

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // Accumulator must stay fully reduced on every Run cycle.
  always @(negedge Clk) begin
    if (busy8 && (u8.r >= {1'b0, P8})) r_viol++;
    if (busy256 && (u256.r >= {1'b0, P256})) r_viol++;
  end

  function automatic logic [7:0] ref8(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] pr;
    pr = 16'(a) * 16'(b);
    return 8'(pr % 16'(P8));
  endfunction

  function automatic logic [255:0] ref256(input logic [255:0] a, input logic [255:0] b);
    logic [511:0] pr;
    pr = {256'b0, a} * {256'b0, b};
    return 256'(pr % {256'b0, P256});
  endfunction

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit full);
    int k, nb;
    logic [7:0] exp;
    @(negedge Clk);
    a8 = a; b8 = b; st8 = 1'b1;
    q8.push_back(ref8(a, b));
    @(posedge Clk); #1;
    st8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom);   // must be ignored during Run
    nb = busy8 ? 1 : 0;
    k = 0;
    while (!done8 && k < 20) begin
      @(posedge Clk); #1;
      k++;
      if (busy8) nb++;
    end
    exp = q8.pop_front();
    if (!done8) chk("op8_done", 256'(done8), 256'd1);
    else begin
      chk("op8_out", 256'(out8), 256'(exp));
      if (full) begin
        chk("op8_lat", 256'(k), 256'd8);
        chk("op8_busy_cyc", 256'(nb), 256'd8);
      end
    end
    @(posedge Clk); #1;
    if (full) begin
      chk("op8_idle_done", 256'(done8), 256'd0);
      chk("op8_idle_hold", 256'(out8), 256'(exp));
    end
  endtask

  task automatic op256(input logic [255:0] a, input logic [255:0] b, input bit full);
    int k;
    logic [255:0] exp;
    @(negedge Clk);
    a256 = a; b256 = b; st256 = 1'b1;
    q256.push_back(ref256(a, b));
    @(posedge Clk); #1;
    st256 = 1'b0;
    a256 = {8{$urandom}}; b256 = {8{$urandom}};
    k = 0;
    while (!done256 && k < 300) begin
      @(posedge Clk); #1;
      k++;
    end
    exp = q256.pop_front();
    if (!done256) chk("op256_done", 256'(done256), 256'd1);
    else begin
      chk("op256_out", out256, exp);
      if (full) chk("op256_lat", 256'(k), 256'd256);
    end
    @(posedge Clk); #1;
    if (full) chk("op256_idle_hold", out256, exp);
  endtask

  initial begin
    logic [255:0] r1, r2;
    rst8 = 1'b1; st8 = 1'b0; a8 = '0; b8 = '0;
    rst256 = 1'b1; st256 = 1'b0; a256 = '0; b256 = '0;
    #12;
    chk("rst_out8", 256'(out8), 256'd0);
    chk("rst_done8", 256'(done8), 256'd0);
    chk("rst_busy8", 256'(busy8), 256'd0);
    chk("rst_out256", out256, 256'd0);
    chk("rst_busy256", 256'(busy256), 256'd0);
    @(negedge Clk);
    rst8 = 1'b0; rst256 = 1'b0;

    // Directed, small modulus
    op8(8'd3, 8'd5, 1);
    op8(8'd250, 8'd250, 1);
    op8(8'd0, 8'hFF, 1);
    op8(8'hFD, 8'd100, 1);

    // Directed, full-size modulus
    op256(P256 - 1, P256 - 1, 1);
    op256(256'd2, P256 - 1, 1);

    // Start held through Finish: no restart, Done stays up
    @(negedge Clk);
    a8 = 8'd11; b8 = 8'd13; st8 = 1'b1;
    q8.push_back(ref8(8'd11, 8'd13));
    repeat (9) @(posedge Clk);
    #1;
    chk("held_done", 256'(done8), 256'd1);
    chk("held_out", 256'(out8), 256'(q8.pop_front()));
    repeat (3) @(posedge Clk);
    #1;
    chk("held_still_done", 256'(done8), 256'd1);
    chk("held_no_busy", 256'(busy8), 256'd0);
    @(negedge Clk); st8 = 1'b0;
    @(posedge Clk); #1;
    chk("drop_idle_done", 256'(done8), 256'd0);
    chk("drop_idle_busy", 256'(busy8), 256'd0);
    op8(8'd7, 8'd9, 1);

    // Asynchronous reset mid-run
    @(negedge Clk);
    a8 = 8'd3; b8 = 8'd5; st8 = 1'b1;
    @(posedge Clk); #1; st8 = 1'b0;
    repeat (4) @(posedge Clk);
    #3 rst8 = 1'b1;
    #1;
    chk("arst_out", 256'(out8), 256'd0);
    chk("arst_done", 256'(done8), 256'd0);
    chk("arst_busy", 256'(busy8), 256'd0);
    @(negedge Clk); rst8 = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    chk("arst_wait_idle", 256'(busy8), 256'd0);
    op8(8'd10, 8'd30, 1);

    // Reset wins over Start on the same edge
    @(negedge Clk); st8 = 1'b1; rst8 = 1'b1;
    @(posedge Clk); #1;
    chk("rst_wins_busy", 256'(busy8), 256'd0);
    @(negedge Clk); rst8 = 1'b0; st8 = 1'b0;

    // Random regression
    for (int i = 0; i < 300; i++)
      op8(8'($urandom), 8'($urandom), 0);
    for (int i = 0; i < 40; i++) begin
      r1 = {8{$urandom}};
      r2 = {8{$urandom}};
      if (i == 0) r1 = '1;           // A >= P path
      if (i == 1) r2 = '0;
      op256(r1, r2, 0);
    end

    chk("r_invariant", 256'(r_viol), 256'd0);
    chk("q8_empty", 256'(q8.size()), 256'd0);
    chk("q256_empty", 256'(q256.size()), 256'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
